multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RV32I datapath (PC, IR, MDR, A/B, ALUOut, register file, unified memory, muxes). It sits upstream of the datapath: it consumes the instruction-register output and the ALU zero flag, and drives every mux select, write enable and ALU control code each cycle. Supported instructions are lw, sw, add, sub, and, or, addi and beq. The PC holds the current instruction's address until retirement; PC+4 or the branch target is written in the instruction's last state.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `inst`  in  32  IR contents; uses opcode [6:0], funct3 [14:12], funct7 bit [30]
- `zero`  in  1  ALU zero flag
- `PCWrite`  out  1  PC write enable
- `IorD`  out  1  memory address select: 1 = ALUOut, 0 = PC
- `MemRead`  out  1  memory read enable
- `MemWrite`  out  1  memory write enable
- `IRWrite`  out  1  IR load enable
- `MemtoReg`  out  1  register write-data select: 1 = MDR, 0 = ALUOut
- `RegWrite`  out  1  register file write enable
- `ALUSrcA`  out  1  ALU A select: 1 = A, 0 = PC
- `ALUSrcB`  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm
- `PCSource`  out  1  PC next-value select: 1 = ALUOut, 0 = ALU result
- `ALUControl`  out  4  ALU code: 0010 add, 0110 sub, 0000 and, 0001 or
- `state`  out  4  current state encoding (debug)
- `halted`  out  1  FSM is in HALT (see Configuration)

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, PCINC=10, HALT=11.
- Default value of every output is 0, with `ALUControl` defaulting to 0010. Each state asserts only the outputs listed for it.
- FETCH: `IorD`=0, `MemRead`, `IRWrite`. Next state DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=10, add, so ALUOut ← PC+imm (branch target). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - anything else → illegal
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: `IorD`=1, `MemRead`. Next state MEMWB.
- MEMWB: `RegWrite`, `MemtoReg`=1, plus PC+4 update. Next state FETCH.
- MEMWR: `IorD`=1, `MemWrite`, plus PC+4 update. Next state FETCH.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00. `ALUControl` by funct3/funct7[30]:
  - 000/0 → add
  - 000/1 → sub
  - 111/0 → and
  - 110/0 → or
  - Next state ALUWB; any other combination is illegal.
- EXEC_I: addi only (funct3 000, else illegal). `ALUSrcA`=1, `ALUSrcB`=10, add. Next state ALUWB.
- ALUWB: `RegWrite`, `MemtoReg`=0, plus PC+4 update. Next state FETCH.
- BRANCH: beq only (funct3 000, else illegal). `ALUSrcA`=1, `ALUSrcB`=00, sub.
  - `PCSource`=1 and `PCWrite`=`zero` (Mealy).
  - Next state FETCH if `zero`, else PCINC.
- PCINC: PC+4 update. Next state FETCH.
- PC+4 update means `ALUSrcA`=0, `ALUSrcB`=01, add, `PCSource`=0, `PCWrite`=1.
- Illegal transitions (including the illegal cases above from EXEC_R, EXEC_I and BRANCH, which are decided in DECODE) follow Configuration.
- Unused encodings 12–15 → FETCH next cycle, with all outputs at default.

## Timing
- All outputs are combinational decodes of the state register. Exceptions: `ALUControl` in EXEC_R also decodes `inst`; `PCWrite` in BRANCH also decodes `zero`.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq taken 3
  - beq not taken 4
- Reset is asynchronous. State goes to FETCH immediately, so outputs immediately show FETCH values (`MemRead`=1, `IRWrite`=1, all others 0 or default) and `halted`=0.
- Reset mid-instruction aborts the instruction. No `RegWrite`, `MemWrite` or `PCWrite` is issued after reset asserts.
- The first FETCH after reset deasserts occupies the first clock edge.

## Configuration
- `CTRL_ILLEGAL_HALT_EN` defined:
  - An illegal instruction goes to HALT.
  - HALT holds all outputs at default with `halted`=1 until reset.
- Not defined:
  - An illegal instruction goes to PCINC and is skipped as a NOP (4 cycles).
  - HALT is unreachable and `halted` is tied to 0.

## Test plan
- Assert reset mid-MEMRD, release → `state`=0, `MemRead`=1, `IRWrite`=1, `RegWrite`=0 at once; next states are 1, then the decode target.
- inst=0x00412283 (lw x5,4(x2)) → states 0,1,2,3,4,0; MEMWB has `RegWrite`=1, `MemtoReg`=1, `PCWrite`=1, `ALUSrcB`=01.
- inst=0x00512423 (sw) → states 0,1,2,5,0; MEMWR has `MemWrite`=1, `IorD`=1, `RegWrite`=0.
- inst=0x40628333 (sub) → EXEC_R `ALUControl`=0110. inst=0x0062F333 (and) → 0000. inst=0x0062E333 (or) → 0001. Each is followed by ALUWB with `RegWrite`=1.
- beq 0x00628463: `zero`=1 in BRANCH → `PCWrite`=1, `PCSource`=1, then FETCH (3 cycles). `zero`=0 → `PCWrite`=0, then PCINC with `PCWrite`=1, `PCSource`=0.
- inst=0x0000007F: with `CTRL_ILLEGAL_HALT_EN` → state 11 and `halted`=1, held for 20 cycles until reset. Without the macro → states 0,1,10,0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath (lw, sw, add, sub, and, or, addi, beq).
// Build option CTRL_ILLEGAL_HALT_EN: illegal instructions park the FSM in HALT instead of being skipped.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCSource,
    output logic [3:0]  ALUControl,
    output logic [3:0]  state,
    output logic        halted
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_PCINC  = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

`ifdef CTRL_ILLEGAL_HALT_EN
    localparam state_t S_ILLEGAL = S_HALT;
`else
    localparam state_t S_ILLEGAL = S_PCINC;
`endif

    state_t     cur_state, nxt_state, decode_target;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b30;
    logic       r_legal;
    logic       unused_inst_bits;

    assign opcode           = inst[6:0];
    assign funct3           = inst[14:12];
    assign funct7_b30       = inst[30];
    assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};
    assign r_legal          = (funct3 == 3'b000) ||
                              (!funct7_b30 && (funct3 == 3'b111 || funct3 == 3'b110));

    // Every illegal case is resolved here so EXEC_R/EXEC_I/BRANCH only ever see legal encodings.
    always_comb begin
        decode_target = S_ILLEGAL;
        case (opcode)
            OP_LW, OP_SW: decode_target = S_MEMADR;
            OP_R:         decode_target = r_legal ? S_EXEC_R : S_ILLEGAL;
            OP_I:         decode_target = (funct3 == 3'b000) ? S_EXEC_I : S_ILLEGAL;
            OP_BR:        decode_target = (funct3 == 3'b000) ? S_BRANCH : S_ILLEGAL;
            default:      decode_target = S_ILLEGAL;
        endcase
    end

    // NOTE: the state flop uses non-blocking assignment so it samples the pre-edge next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= nxt_state;
    end

    // NOTE: all outputs take their defaults before the case, so no path can infer a latch.
    always_comb begin
        nxt_state  = S_FETCH;
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 1'b0;
        ALUControl = ALU_ADD;
        case (cur_state)
            S_FETCH: begin
                MemRead   = 1'b1;
                IRWrite   = 1'b1;
                nxt_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b10;
                nxt_state = decode_target;
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD      = 1'b1;
                MemRead   = 1'b1;
                nxt_state = S_MEMWB;
            end
            // PC+4 update: ALUSrcA=0, add and PCSource=0 are already the defaults.
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                ALUSrcB  = 2'b01;
                PCWrite  = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                ALUSrcB  = 2'b01;
                PCWrite  = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA   = 1'b1;
                nxt_state = S_ALUWB;
                case (funct3)
                    3'b000:  ALUControl = funct7_b30 ? ALU_SUB : ALU_ADD;
                    3'b111:  ALUControl = ALU_AND;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                ALUSrcB  = 2'b01;
                PCWrite  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSource   = 1'b1;
                PCWrite    = zero;
                nxt_state  = zero ? S_FETCH : S_PCINC;
            end
            S_PCINC: begin
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
            end
`ifdef CTRL_ILLEGAL_HALT_EN
            S_HALT:  nxt_state = S_HALT;
`endif
            default: nxt_state = S_FETCH;
        endcase
    end

    assign state = cur_state;

`ifdef CTRL_ILLEGAL_HALT_EN
    assign halted = (cur_state == S_HALT);
`else
    assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions plus random ones against an
// instruction-level model that lists each instruction's state walk and per-state control values.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic        zero;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, PCSource;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUControl;
    logic [3:0]  state;
    logic        halted;

    multicycle_control dut (
        .clk(clk), .reset(reset), .inst(inst), .zero(zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUControl(ALUControl),
        .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

`ifdef CTRL_ILLEGAL_HALT_EN
    localparam int ILL_STATE = 11;
`else
    localparam int ILL_STATE = 10;
`endif

    typedef struct packed {
        logic       halted;
        logic       pcw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic       pcs;
        logic [3:0] aluc;
    } ctrl_t;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ctrl_t observed_ctrl();
        return {halted, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, ALUControl};
    endfunction

    // Control values each state is defined to drive; everything else stays at its default.
    function automatic ctrl_t expected_ctrl(input int st, input logic [31:0] in, input logic z);
        ctrl_t c;
        c      = '0;
        c.aluc = 4'b0010;
        case (st)
            0:  begin c.mr = 1'b1; c.irw = 1'b1; end
            1:  c.asb = 2'b10;
            2:  begin c.asa = 1'b1; c.asb = 2'b10; end
            3:  begin c.iord = 1'b1; c.mr = 1'b1; end
            4:  begin c.rw = 1'b1; c.m2r = 1'b1; end
            5:  begin c.iord = 1'b1; c.mw = 1'b1; end
            6:  begin
                c.asa = 1'b1;
                if (in[14:12] == 3'b000)      c.aluc = in[30] ? 4'b0110 : 4'b0010;
                else if (in[14:12] == 3'b111) c.aluc = 4'b0000;
                else if (in[14:12] == 3'b110) c.aluc = 4'b0001;
            end
            7:  begin c.asa = 1'b1; c.asb = 2'b10; end
            8:  c.rw = 1'b1;
            9:  begin c.asa = 1'b1; c.aluc = 4'b0110; c.pcs = 1'b1; c.pcw = z; end
            11: c.halted = 1'b1;
            default: ;
        endcase
        if (st == 4 || st == 5 || st == 8 || st == 10) begin
            c.asb = 2'b01;
            c.pcw = 1'b1;
        end
        return c;
    endfunction

    // State walk of a whole instruction, classified from its encoding.
    function automatic void build_seq(input logic [31:0] in, input logic z);
        logic [6:0] op;
        logic [2:0] f3;
        op = in[6:0];
        f3 = in[14:12];
        exp_q = {0, 1};
        if (op == 7'b0000011)      exp_q = {exp_q, 2, 3, 4};
        else if (op == 7'b0100011) exp_q = {exp_q, 2, 5};
        else if (op == 7'b0110011 &&
                 (f3 == 3'b000 || (!in[30] && (f3 == 3'b111 || f3 == 3'b110))))
                                   exp_q = {exp_q, 6, 8};
        else if (op == 7'b0010011 && f3 == 3'b000) exp_q = {exp_q, 7, 8};
        else if (op == 7'b1100011 && f3 == 3'b000) exp_q = z ? {exp_q, 9} : {exp_q, 9, 10};
        else                       exp_q.push_back(ILL_STATE);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [2:0]  f3;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return {r[31:7], 7'b0000011};
            1: return {r[31:7], 7'b0100011};
            2: begin
                case ($urandom_range(0, 3))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b111;
                    2:       f3 = 3'b110;
                    default: f3 = r[14:12];
                endcase
                return {1'b0, r[30], 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
            end
            3: begin
                f3 = ($urandom_range(0, 3) == 0) ? r[14:12] : 3'b000;
                return {r[31:15], f3, r[11:7], 7'b0010011};
            end
            4: begin
                f3 = ($urandom_range(0, 3) == 0) ? r[14:12] : 3'b000;
                return {r[31:15], f3, r[11:7], 7'b1100011};
            end
            default: begin
                do op = 7'($urandom);
                while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011});
                return {r[31:7], op};
            end
        endcase
    endfunction

    // Entered and left at 1 time unit after a rising edge with the DUT in FETCH.
    task automatic run_inst(input logic [31:0] in, input logic z, input string name);
        inst = in;
        build_seq(in, z);
        foreach (exp_q[k]) begin
            zero = (exp_q[k] == 9) ? z : 1'($urandom_range(0, 1));
            #1;
            check({name, " state"}, 32'(state), 32'(exp_q[k]));
            check({name, " ctrl"}, 32'(observed_ctrl()), 32'(expected_ctrl(exp_q[k], in, zero)));
            @(posedge clk);
            #1;
        end
        if (exp_q[exp_q.size() - 1] == 11) begin
            for (int c = 0; c < 20; c++) begin
                zero = 1'($urandom_range(0, 1));
                #1;
                check({name, " halt state"}, 32'(state), 32'd11);
                check({name, " halt ctrl"}, 32'(observed_ctrl()), 32'(expected_ctrl(11, in, zero)));
                @(posedge clk);
                #1;
            end
            reset = 1'b1;
            #1;
            check({name, " halt reset"}, 32'(observed_ctrl()), 32'(expected_ctrl(0, in, zero)));
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        zero  = 1'b0;
        inst  = 32'h0000_0013;
        #1;
        check("reset state", 32'(state), 32'd0);
        check("reset ctrl", 32'(observed_ctrl()), 32'(expected_ctrl(0, inst, zero)));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Abort an lw in MEMRD with an asynchronous reset.
        inst = 32'h0041_2283;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("abort walk", 32'(state), 32'(k));
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        reset = 1'b1;
        #1;
        check("abort state", 32'(state), 32'd0);
        check("abort MemRead", 32'(MemRead), 32'd1);
        check("abort IRWrite", 32'(IRWrite), 32'd1);
        check("abort RegWrite", 32'(RegWrite), 32'd0);
        check("abort PCWrite", 32'(PCWrite), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_inst(32'h0041_2283, 1'b0, "lw");
        run_inst(32'h0051_2423, 1'b0, "sw");
        run_inst(32'h0062_8333, 1'b0, "add");
        run_inst(32'h4062_8333, 1'b0, "sub");
        run_inst(32'h0062_F333, 1'b0, "and");
        run_inst(32'h0062_E333, 1'b0, "or");
        run_inst(32'h4062_F333, 1'b0, "bad r-type");
        run_inst(32'h0050_0293, 1'b0, "addi");
        run_inst(32'h0050_1293, 1'b0, "bad i-type");
        run_inst(32'h0062_8463, 1'b1, "beq taken");
        run_inst(32'h0062_8463, 1'b0, "beq not taken");
        run_inst(32'h0062_9463, 1'b1, "bne illegal");
        run_inst(32'h0000_007F, 1'b0, "illegal op");

        for (int n = 0; n < 150; n++) begin
            run_inst(rand_inst(), 1'($urandom_range(0, 1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
